pht_update_sequencer: RTL and testbench

//  Owns the single-port Pattern History Table (2-bit counters, synchronous read) and shares it between two requesters:
//  IF-stage prediction lookups and EX-stage branch-resolution updates.

---
 rtl/pht_update_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_pht_update_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pht_update_sequencer.sv
// Shares a single-port 2-bit-counter PHT between IF lookups (same-cycle priority) and queued EX
// read-modify-write updates; sweeps the table to INIT_VAL after reset. Optional: PHT_STARVE_GUARD_EN.
module pht_update_sequencer #(
    parameter int         IDX_W      = 6,
    parameter int         QDEPTH     = 4,
    parameter logic [1:0] INIT_VAL   = 2'b01,
    parameter int         STARVE_MAX = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lookup_valid,
    input  logic [IDX_W-1:0] lookup_idx,
    output logic             lookup_ready,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    output logic             upd_ready,
    output logic             pht_en,
    output logic             pht_we,
    output logic [IDX_W-1:0] pht_addr,
    output logic [1:0]       pht_wdata,
    input  logic [1:0]       pht_rdata,
    output logic             busy
);

    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_WR   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] init_cnt_q, init_cnt_d;
    logic [1:0]       prev_q, prev_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] fifo_idx_q [QDEPTH];
    logic [IDX_W-1:0] fifo_idx_d [QDEPTH];
    logic             fifo_tkn_q [QDEPTH];
    logic             fifo_tkn_d [QDEPTH];

    logic             rmw_pending;
    logic             rmw_go;
    logic             force_rmw;
    logic             lookup_grant;
    logic             push;
    logic             pop;
    logic             upd_ready_c;
    logic             en_c;
    logic             we_c;
    logic [IDX_W-1:0] addr_c;
    logic [1:0]       wdata_c;
    logic [IDX_W-1:0] head_idx;
    logic             head_tkn;

    function automatic logic [1:0] sat_next(input logic [1:0] prev, input logic taken);
        if (taken)
            return (prev == 2'b11) ? 2'b11 : prev + 2'b01;
        else
            return (prev == 2'b00) ? 2'b00 : prev - 2'b01;
    endfunction

    assign head_idx    = fifo_idx_q[rd_ptr_q];
    assign head_tkn    = fifo_tkn_q[rd_ptr_q];
    // A pending RMW step is either the head read (IDLE) or the deferred write (WR).
    assign rmw_pending = ((state_q == ST_IDLE) && (count_q != '0)) || (state_q == ST_WR);
    assign rmw_go       = rmw_pending && (!lookup_valid || force_rmw);
    assign lookup_grant = lookup_valid && (state_q != ST_INIT) && !force_rmw;
    assign upd_ready_c  = (count_q < CNT_W'(QDEPTH)) && (state_q != ST_INIT);
    assign push         = upd_valid && upd_ready_c;
    assign pop          = (state_q == ST_WR) && rmw_go;

`ifdef PHT_STARVE_GUARD_EN
    localparam int SV_W = $clog2(STARVE_MAX + 1);
    logic [SV_W-1:0] starve_q, starve_d;

    assign force_rmw = rmw_pending && (starve_q == SV_W'(STARVE_MAX));

    always_comb begin
        starve_d = starve_q;
        if (rmw_go)
            starve_d = '0;
        else if (rmw_pending && lookup_valid)
            starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            starve_q <= '0;
        else
            starve_q <= starve_d;
    end
`else
    assign force_rmw = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        prev_d     = prev_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        fifo_idx_d = fifo_idx_q;
        fifo_tkn_d = fifo_tkn_q;
        en_c       = 1'b0;
        we_c       = 1'b0;
        addr_c     = '0;
        wdata_c    = '0;

        case (state_q)
            ST_INIT: begin
                en_c       = 1'b1;
                we_c       = 1'b1;
                addr_c     = init_cnt_q;
                wdata_c    = INIT_VAL;
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == {IDX_W{1'b1}})
                    state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (rmw_go)
                    state_d = ST_WAIT;
            end
            ST_WAIT: begin
                prev_d  = pht_rdata;
                state_d = ST_WR;
            end
            default: begin
                if (rmw_go)
                    state_d = ST_IDLE;
            end
        endcase

        if (state_q != ST_INIT) begin
            if (lookup_grant) begin
                en_c   = 1'b1;
                addr_c = lookup_idx;
            end else if (rmw_go) begin
                en_c   = 1'b1;
                addr_c = head_idx;
                if (state_q == ST_WR) begin
                    we_c    = 1'b1;
                    wdata_c = sat_next(prev_q, head_tkn);
                end
            end
        end

        if (push) begin
            fifo_idx_d[wr_ptr_q] = upd_idx;
            fifo_tkn_d[wr_ptr_q] = upd_taken;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            prev_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                fifo_idx_q[i] <= '0;
                fifo_tkn_q[i] <= 1'b0;
            end
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            prev_q     <= prev_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            fifo_idx_q <= fifo_idx_d;
            fifo_tkn_q <= fifo_tkn_d;
        end
    end

    // Outputs are forced low for the whole time reset is asserted, not just after the first edge.
    assign pht_en       = en_c & ~rst;
    assign pht_we       = we_c & ~rst;
    assign pht_addr     = rst ? '0 : addr_c;
    assign pht_wdata    = rst ? '0 : wdata_c;
    assign lookup_ready = lookup_grant & ~rst;
    assign upd_ready    = upd_ready_c & ~rst;
    assign busy         = ((state_q != ST_IDLE) || (count_q != '0)) & ~rst;

endmodule

// File: tb/tb_pht_update_sequencer.sv
// Directed bench for pht_update_sequencer (IDX_W=3) with a behavioural synchronous-read PHT.
module tb_pht_update_sequencer;

    logic       clk;
    logic       rst;
    logic       lookup_valid;
    logic [2:0] lookup_idx;
    logic       lookup_ready;
    logic       upd_valid;
    logic [2:0] upd_idx;
    logic       upd_taken;
    logic       upd_ready;
    logic       pht_en;
    logic       pht_we;
    logic [2:0] pht_addr;
    logic [1:0] pht_wdata;
    logic [1:0] pht_rdata;
    logic       busy;

    logic [1:0] mem [8];
    int         tests;
    int         fails;

    pht_update_sequencer #(
        .IDX_W(3), .QDEPTH(4), .INIT_VAL(2'b01), .STARVE_MAX(8)
    ) dut (
        .clk(clk), .rst(rst),
        .lookup_valid(lookup_valid), .lookup_idx(lookup_idx), .lookup_ready(lookup_ready),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_ready(upd_ready),
        .pht_en(pht_en), .pht_we(pht_we), .pht_addr(pht_addr), .pht_wdata(pht_wdata),
        .pht_rdata(pht_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pht_en) begin
            if (pht_we)
                mem[pht_addr] <= pht_wdata;
            else
                pht_rdata <= mem[pht_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        #1;
        while (busy && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("idle_timeout_busy", busy, 0);
    endtask

    task automatic do_push(input logic [2:0] idx, input logic tkn);
        upd_valid = 1'b1;
        upd_idx   = idx;
        upd_taken = tkn;
        #1;
        check("push_upd_ready", upd_ready, 1);
        @(negedge clk);
        upd_valid = 1'b0;
    endtask

    logic [2:0] wr_addr [4];
    logic [1:0] wr_data [4];
    logic [2:0] exp_addr [4];
    logic [1:0] exp_data [4];
    logic       push_tkn [4];
    int         nw;

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        lookup_valid = 1'b0;
        lookup_idx = '0;
        upd_valid = 1'b0;
        upd_idx = '0;
        upd_taken = 1'b0;
        pht_rdata = '0;

        // Reset: all outputs low while rst is held
        #1;
        check("rst_pht_en", pht_en, 0);
        check("rst_busy", busy, 0);
        check("rst_upd_ready", upd_ready, 0);
        @(negedge clk);
        rst = 1'b0;

        // Init sweep: 8 writes of 01 to addr 0..7
        for (int i = 0; i < 8; i++) begin
            #1;
            check("init_we", {pht_en, pht_we}, 2'b11);
            check("init_addr", pht_addr, i);
            check("init_wdata", pht_wdata, 2'b01);
            check("init_ready", {lookup_ready, upd_ready}, 2'b00);
            $display("[TB] init cycle %0d addr=%0d wdata=%0b", i, pht_addr, pht_wdata);
            @(negedge clk);
        end
        #1;
        check("post_init_busy", busy, 0);
        check("post_init_upd_ready", upd_ready, 1);
        check("post_init_mem7", mem[7], 2'b01);

        // Uncontended update idx5 taken: read at T+1, write 10 at T+3, idle at T+4
        upd_valid = 1'b1; upd_idx = 3'd5; upd_taken = 1'b1;
        #1;
        check("t2_T_en", pht_en, 0);
        @(negedge clk);
        upd_valid = 1'b0;
        #1;
        check("t2_T1_read", {pht_en, pht_we, pht_addr}, {2'b10, 3'd5});
        check("t2_T1_busy", busy, 1);
        @(negedge clk); #1;
        check("t2_T2_en", pht_en, 0);
        @(negedge clk); #1;
        check("t2_T3_write", {pht_en, pht_we, pht_addr, pht_wdata}, {2'b11, 3'd5, 2'b10});
        @(negedge clk); #1;
        check("t2_T4_busy", busy, 0);
        check("t2_mem5", mem[5], 2'b10);
        $display("[TB] update idx5 taken -> %0b", mem[5]);

        // Saturation at both ends
        mem[2] = 2'b11;
        do_push(3'd2, 1'b1);
        wait_idle();
        check("sat_hi_mem2", mem[2], 2'b11);
        mem[2] = 2'b00;
        do_push(3'd2, 1'b0);
        wait_idle();
        check("sat_lo_mem2", mem[2], 2'b00);
        do_push(3'd4, 1'b1);
        do_push(3'd4, 1'b1);
        do_push(3'd4, 1'b1);
        wait_idle();
        check("sat_3taken_mem4", mem[4], 2'b11);
        $display("[TB] saturation idx2=%0b idx4=%0b", mem[2], mem[4]);

        // Contention in WR: lookups of idx1 (=11) must not disturb prev_q (=01 from idx6)
        mem[6] = 2'b01;
        mem[1] = 2'b11;
        do_push(3'd6, 1'b1);
        @(negedge clk);
        @(negedge clk);
        lookup_valid = 1'b1; lookup_idx = 3'd1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("cont_lookup_ready", lookup_ready, 1);
            check("cont_port", {pht_en, pht_we, pht_addr}, {2'b10, 3'd1});
            @(negedge clk);
        end
        lookup_valid = 1'b0;
        #1;
        check("cont_deferred_write", {pht_en, pht_we, pht_addr, pht_wdata}, {2'b11, 3'd6, 2'b10});
        wait_idle();
        check("cont_mem6", mem[6], 2'b10);
        $display("[TB] contention idx6 -> %0b", mem[6]);

        // FIFO full under constant lookups, then ordered drain
        exp_addr[0] = 3'd3; exp_data[0] = 2'b10; push_tkn[0] = 1'b1;
        exp_addr[1] = 3'd7; exp_data[1] = 2'b00; push_tkn[1] = 1'b0;
        exp_addr[2] = 3'd0; exp_data[2] = 2'b10; push_tkn[2] = 1'b1;
        exp_addr[3] = 3'd3; exp_data[3] = 2'b11; push_tkn[3] = 1'b1;
        lookup_valid = 1'b1; lookup_idx = 3'd4;
        for (int i = 0; i < 4; i++) begin
            upd_valid = 1'b1; upd_idx = exp_addr[i]; upd_taken = push_tkn[i];
            #1;
            check("full_push_ready", upd_ready, 1);
            check("full_lookup_ready", lookup_ready, 1);
            check("full_no_write", pht_we, 0);
            @(negedge clk);
        end
        upd_valid = 1'b1; upd_idx = 3'd5; upd_taken = 1'b1;
        #1;
        check("full_5th_refused", upd_ready, 0);
        @(negedge clk);
        upd_valid = 1'b0;
        lookup_valid = 1'b0;
        nw = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (pht_en && pht_we) begin
                if (nw < 4) begin
                    wr_addr[nw] = pht_addr;
                    wr_data[nw] = pht_wdata;
                end
                nw++;
            end
            if (!busy) break;
            @(negedge clk);
        end
        check("drain_count", nw, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < nw) begin
                check("drain_addr", wr_addr[i], exp_addr[i]);
                check("drain_data", wr_data[i], exp_data[i]);
                $display("[TB] drain write %0d addr=%0d data=%0b", i, wr_addr[i], wr_data[i]);
            end
        end

        // Starvation with lookups stuck high; idx5 holds 10
        lookup_valid = 1'b1; lookup_idx = 3'd0;
        do_push(3'd5, 1'b1);
`ifdef PHT_STARVE_GUARD_EN
        for (int i = 1; i <= 8; i++) begin
            #1;
            check("starve_lookup_ready", lookup_ready, 1);
            @(negedge clk);
        end
        #1;
        check("starve_forced_ready", lookup_ready, 0);
        check("starve_forced_read", {pht_en, pht_we, pht_addr}, {2'b10, 3'd5});
        $display("[TB] starve guard forced read of idx5");
        @(negedge clk);
`else
        for (int i = 1; i <= 12; i++) begin
            #1;
            check("nostarve_lookup_ready", lookup_ready, 1);
            check("nostarve_port", {pht_en, pht_we, pht_addr}, {2'b10, 3'd0});
            @(negedge clk);
        end
        $display("[TB] no starve guard: update held for 12 cycles");
`endif
        lookup_valid = 1'b0;
        wait_idle();
        check("starve_mem5", mem[5], 2'b11);

        // Reset mid-WR with a second entry queued
        upd_valid = 1'b1; upd_idx = 3'd2; upd_taken = 1'b1;
        @(negedge clk);
        upd_idx = 3'd3; upd_taken = 1'b0;
        @(negedge clk);
        upd_valid = 1'b0;
        @(negedge clk);
        #1;
        check("rmw_wr_reached", {pht_en, pht_we, pht_addr}, {2'b11, 3'd2});
        rst = 1'b1;
        #1;
        check("midrst_outputs", {pht_en, pht_we, lookup_ready, upd_ready, busy}, 5'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("reinit_write", {pht_en, pht_we, pht_addr}, {2'b11, 3'(i)});
            @(negedge clk);
        end
        for (int i = 0; i < 5; i++) begin
            #1;
            check("reinit_fifo_empty", {pht_en, busy, upd_ready}, 3'b001);
            @(negedge clk);
        end
        check("reinit_mem5", mem[5], 2'b01);
        $display("[TB] mid-WR reset: sweep restarted at 0, queue discarded");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
